seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl_if.sv | 29 ++
 rtl/seq_det_ctrl.sv | 127 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Configuration, run-control, serial data and result signals of the sequence detector.
interface seq_det_ctrl_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               start;
    logic               stop;
    logic               din_valid;
    logic               din;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, start, stop, din_valid, din,
        input  cfg_ready, cfg_err, match, match_count, busy
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, start, stop, din_valid, din,
        output cfg_ready, cfg_err, match, match_count, busy
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: latches a pattern in IDLE, counts matches
// on the qualified bit stream in RUN, with overlapping or non-overlapping detection.
module seq_det_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_ctrl_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               cfgd_q, cfgd_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic               cfg_legal;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    // Compare window and next-bit view of history/fill, shared by the FSM below
    always_comb begin
        cfg_legal = (bus.cfg_len != 4'd0) && (32'(bus.cfg_len) <= MAX_LEN);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (32'(i) < 32'(len_q));
        end
        hist_nxt = MAX_LEN'({hist_q, bus.din});
        fill_inc = (32'(fill_q) < MAX_LEN) ? (fill_q + FILL_W'(1)) : fill_q;
        hit      = (32'(fill_inc) >= 32'(len_q)) &&
                   ((hist_nxt & len_mask) == (pat_q & len_mask));
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cfgd_d  = cfgd_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    if (cfg_legal) begin
                        pat_d  = bus.cfg_pattern;
                        len_d  = bus.cfg_len;
                        ovl_d  = bus.cfg_overlap;
                        cfgd_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Start qualifies on the flag as it stood before this cycle's offer
                if (bus.start && cfgd_q) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.din_valid) begin
                    hist_d = hist_nxt;
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                        if (!ovl_q) fill_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            cfgd_q  <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            cfgd_q  <= cfgd_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    assign bus.cfg_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q == RUN);
    assign bus.match       = match_q;
    assign bus.cfg_err     = err_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed vector table, hand sequences and random traffic
// checked against a bit-queue reference model; a CNT_W=2 copy covers saturation.
module tb_seq_det_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus1 ();
    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        logic       rst, cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl, st, sp, dv, d;
        logic       e_busy, e_match, e_err;
        logic [7:0] e_cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit       m_run, m_cfgd, m_ovl, m_match, m_err;
    bit [7:0] m_pat;
    int       m_len, m_cnt1, m_cnt2;
    bit       m_hist[$];

    function automatic vec_t mk(input logic r, cv, input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, st, sp, dv, d,
                                input logic eb, em, ee, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.cv = cv; v.pat = pat; v.len = len; v.ovl = ovl;
        v.st = st; v.sp = sp; v.dv = dv; v.d = d;
        v.e_busy = eb; v.e_match = em; v.e_err = ee; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level behaviour: bits since the last clear kept in a queue, newest at the back
    task automatic model_step(input vec_t v);
        bit was_cfgd;
        bit ok;
        if (v.rst) begin
            m_run = 0; m_cfgd = 0; m_ovl = 0; m_pat = '0; m_len = 0;
            m_cnt1 = 0; m_cnt2 = 0; m_match = 0; m_err = 0;
            m_hist.delete();
            return;
        end
        m_match = 0;
        m_err   = 0;
        if (!m_run) begin
            was_cfgd = m_cfgd;
            if (v.cv) begin
                if (v.len >= 1 && v.len <= 8) begin
                    m_pat = v.pat; m_len = int'(v.len); m_ovl = v.ovl; m_cfgd = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (v.st && was_cfgd) begin
                m_run = 1; m_cnt1 = 0; m_cnt2 = 0;
                m_hist.delete();
            end
        end else if (v.sp) begin
            m_run = 0;
        end else if (v.dv) begin
            m_hist.push_back(v.d);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            ok = (m_hist.size() >= m_len);
            for (int j = 0; j < m_len && ok; j++)
                if (m_hist[m_hist.size() - 1 - j] != m_pat[j]) ok = 0;
            if (ok) begin
                m_match = 1;
                m_cnt1  = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
                m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                if (!m_ovl) m_hist.delete();
            end
        end
    endtask

    // Drive one cycle into both DUTs, advance the model, then compare after the edge
    task automatic cyc(input vec_t v);
        rst = v.rst;
        bus1.cfg_valid = v.cv; bus1.cfg_pattern = v.pat; bus1.cfg_len = v.len;
        bus1.cfg_overlap = v.ovl; bus1.start = v.st; bus1.stop = v.sp;
        bus1.din_valid = v.dv; bus1.din = v.d;
        bus2.cfg_valid = v.cv; bus2.cfg_pattern = v.pat; bus2.cfg_len = v.len;
        bus2.cfg_overlap = v.ovl; bus2.start = v.st; bus2.stop = v.sp;
        bus2.din_valid = v.dv; bus2.din = v.d;
        model_step(v);
        @(posedge clk);
        #1;
        check("busy",        int'(bus1.busy),        int'(m_run));
        check("cfg_ready",   int'(bus1.cfg_ready),   int'(!m_run));
        check("match",       int'(bus1.match),       int'(m_match));
        check("cfg_err",     int'(bus1.cfg_err),     int'(m_err));
        check("match_count", int'(bus1.match_count), m_cnt1);
        check("match_w2",    int'(bus2.match),       int'(m_match));
        check("count_w2",    int'(bus2.match_count), m_cnt2);
    endtask

    function automatic vec_t bitv(input logic b, input logic em, input logic [7:0] ec);
        return mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, b, 1, em, 0, ec);
    endfunction

    vec_t tbl[$];
    vec_t v;

    initial begin
        bus1.cfg_valid = 0; bus1.cfg_pattern = '0; bus1.cfg_len = '0; bus1.cfg_overlap = 0;
        bus1.start = 0; bus1.stop = 0; bus1.din_valid = 0; bus1.din = 0;
        bus2.cfg_valid = 0; bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 0;
        bus2.start = 0; bus2.stop = 0; bus2.din_valid = 0; bus2.din = 0;

        // overlapping 1011 over 1,0,1,1,0,1,1; start+stop in RUN acts as stop
        tbl.push_back(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(0, 0, 1)); tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(bitv(1, 1, 2));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        // non-overlapping; start+stop in IDLE acts as start; cfg offer in RUN ignored
        tbl.push_back(mk(0, 1, 8'h0B, 4'd4, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(1, 1, 1));
        tbl.push_back(bitv(0, 0, 1)); tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(bitv(1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // illegal lengths after reset: two cfg_err pulses, start ignored
        tbl.push_back(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h0B, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h0B, 4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // stop together with the completing bit discards it
        tbl.push_back(mk(0, 1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0)); tbl.push_back(bitv(1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // reset mid-RUN, then start without reconfiguration is ignored
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(bitv(1, 0, 0)); tbl.push_back(bitv(0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i]);
            check($sformatf("tbl%0d_busy", i),  int'(bus1.busy),        int'(tbl[i].e_busy));
            check($sformatf("tbl%0d_match", i), int'(bus1.match),       int'(tbl[i].e_match));
            check($sformatf("tbl%0d_err", i),   int'(bus1.cfg_err),     int'(tbl[i].e_err));
            check($sformatf("tbl%0d_cnt", i),   int'(bus1.match_count), int'(tbl[i].e_cnt));
        end

        // saturation: pattern '1', len 1, five 1-bits on the 2-bit counter copy
        cyc(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(mk(0, 1, 8'h01, 4'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            cyc(bitv(1, 0, 0));
            check($sformatf("sat_match%0d", k), int'(bus2.match), 1);
        end
        check("sat_count_w2", int'(bus2.match_count), 3);
        check("sat_count_w8", int'(bus1.match_count), 5);
        cyc(mk(0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        check("sat_hold_idle", int'(bus2.match_count), 3);

        // random traffic against the model
        cyc(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            v = mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (r < 1) begin
                v.rst = 1;
            end else if (r < 5) begin
                v.cv  = 1;
                v.pat = 8'($urandom);
                v.len = 4'($urandom_range(0, 9));
                v.ovl = 1'($urandom);
            end else if (r < 8) begin
                v.st = 1;
                v.sp = 1'($urandom_range(0, 3) == 0);
            end else if (r < 10) begin
                v.sp = 1;
                v.dv = 1'($urandom);
                v.d  = 1'($urandom);
            end else begin
                v.dv = 1'($urandom_range(0, 3) != 0);
                v.d  = 1'($urandom);
            end
            cyc(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
